quad_step_decoder: RTL and testbench



---
 rtl/quad_step_if.sv | 25 ++
 rtl/quad_step_decoder.sv | 135 +++++++++++++
 tb/tb_quad_step_decoder.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/quad_step_if.sv
// Pin-side quadrature channels and clear in; decoded step/error events and position out.
// en and err are single-cycle pulses with no back-pressure; dn and pos are levels that hold between steps.
interface quad_step_if #(
  parameter int POS_W = 8
);
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             en;
  logic             dn;
  logic [POS_W-1:0] pos;
  logic             err;
  logic             err_flag;
  logic             state_dbg;

  modport master (
    output a_in, b_in, clr,
    input  en, dn, pos, err, err_flag, state_dbg
  );

  modport slave (
    input  a_in, b_in, clr,
    output en, dn, pos, err, err_flag, state_dbg
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature receiver: per-channel 2-flop sync and debounce, then Gray-code step decode.
// Keeps a wrapping position count and flags illegal double transitions.
module quad_step_decoder #(
  parameter int DEB_CYCLES = 4,
  parameter int POS_W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  quad_step_if.slave   bus
);

  typedef enum logic {ST_ARMING = 1'b0, ST_RUNNING = 1'b1} state_e;

  localparam logic [7:0]       DEB      = 8'(DEB_CYCLES);
  localparam logic [8:0]       ARM_LAST = 9'(DEB_CYCLES + 2);
  localparam logic [POS_W-1:0] POS_ONE  = {{(POS_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [8:0]       arm_cnt_q, arm_cnt_d;
  logic [1:0]       s1_q, s1_d;
  logic [1:0]       s2_q, s2_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       prev_q, prev_d;
  logic [1:0][7:0]  cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic             err_flag_q, err_flag_d;
  logic [POS_W-1:0] pos_q, pos_d;

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    s1_d       = {bus.a_in, bus.b_in};
    s2_d       = s1_q;
    filt_d     = filt_q;
    prev_d     = filt_q;
    cnt_d      = cnt_q;
    en_d       = 1'b0;
    dn_d       = dn_q;
    err_d      = 1'b0;
    err_flag_d = err_flag_q;
    pos_d      = pos_q;

    case (state_q)
      // Power-up window: track the pins directly so a non-zero idle level is not seen as a step.
      ST_ARMING: begin
        filt_d    = s2_q;
        cnt_d     = '0;
        arm_cnt_d = arm_cnt_q + 9'd1;
        if (arm_cnt_q == ARM_LAST) begin
          state_d   = ST_RUNNING;
          arm_cnt_d = '0;
        end
      end
      default: begin
        for (int i = 0; i < 2; i++) begin
          if (s2_q[i] != filt_q[i]) begin
            if (cnt_q[i] + 8'd1 == DEB) begin
              filt_d[i] = s2_q[i];
              cnt_d[i]  = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end else begin
            cnt_d[i] = '0;
          end
        end

        if (prev_q != filt_q) begin
          case ({prev_q, filt_q})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: begin
              en_d  = 1'b1;
              dn_d  = 1'b0;
              pos_d = pos_q + POS_ONE;
            end
            4'b0010, 4'b1011, 4'b1101, 4'b0100: begin
              en_d  = 1'b1;
              dn_d  = 1'b1;
              pos_d = pos_q - POS_ONE;
            end
            default: begin
              err_d      = 1'b1;
              err_flag_d = 1'b1;
            end
          endcase
        end
      end
    endcase

    // Clear overrides any concurrent step or error update of the count and sticky flag.
    if (bus.clr) begin
      pos_d      = '0;
      err_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARMING;
      arm_cnt_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      filt_q     <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      dn_q       <= 1'b0;
      err_q      <= 1'b0;
      err_flag_q <= 1'b0;
      pos_q      <= '0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      filt_q     <= filt_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      dn_q       <= dn_d;
      err_q      <= err_d;
      err_flag_q <= err_flag_d;
      pos_q      <= pos_d;
    end
  end

  assign bus.en        = en_q;
  assign bus.dn        = dn_q;
  assign bus.err       = err_q;
  assign bus.err_flag  = err_flag_q;
  assign bus.pos       = pos_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder with DEB_CYCLES=4, POS_W=8.
// Each step holds its input level 10 cycles; a legal change pulses en 7 edges later.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic rst;

  quad_step_if #(.POS_W(8)) bus ();

  quad_step_decoder #(
    .DEB_CYCLES(4),
    .POS_W     (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_bad    = 0;
  int en_cnt   = 0;
  int err_cnt  = 0;
  int first_en = 0;
  int first_er = 0;
  int cyc_base = 0;
  int both_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_counts();
    en_cnt   = 0;
    err_cnt  = 0;
    first_en = 0;
    first_er = 0;
    cyc_base = 0;
  endtask

  // Counts en/err pulses over n edges, sampling 1 ns after each rising edge.
  task automatic watch(input int n);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (bus.en) begin
        en_cnt++;
        if (first_en == 0) first_en = cyc_base + k;
      end
      if (bus.err) begin
        err_cnt++;
        if (first_er == 0) first_er = cyc_base + k;
      end
      if (bus.en && bus.err) both_cnt++;
    end
    cyc_base += n;
  endtask

  task automatic do_reset(input logic a, input logic b);
    bus.a_in = a;
    bus.b_in = b;
    bus.clr  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic step(input string tag, input logic a, input logic b,
                      input logic exp_dn, input logic [7:0] exp_pos);
    bus.a_in = a;
    bus.b_in = b;
    clr_counts();
    watch(10);
    chk({tag, "_en_count"}, 32'(en_cnt), 32'd1);
    chk({tag, "_en_edge"},  32'(first_en), 32'd7);
    chk({tag, "_err_count"}, 32'(err_cnt), 32'd0);
    chk({tag, "_dn"},  32'(bus.dn), 32'(exp_dn));
    chk({tag, "_pos"}, 32'(bus.pos), 32'(exp_pos));
  endtask

  initial begin
    // Reset with both channels high at power-up.
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    bus.clr  = 1'b0;
    rst      = 1'b1;
    #1;
    chk("rst_en",       32'(bus.en), 32'd0);
    chk("rst_dn",       32'(bus.dn), 32'd0);
    chk("rst_pos",      32'(bus.pos), 32'd0);
    chk("rst_err",      32'(bus.err), 32'd0);
    chk("rst_err_flag", 32'(bus.err_flag), 32'd0);
    do_reset(1'b1, 1'b1);
    clr_counts();
    watch(20);
    chk("pwr11_en_count",  32'(en_cnt), 32'd0);
    chk("pwr11_err_count", 32'(err_cnt), 32'd0);
    chk("pwr11_pos",       32'(bus.pos), 32'd0);
    chk("pwr11_dn",        32'(bus.dn), 32'd0);

    // Restart from AB=00 and walk forward one full cycle.
    do_reset(1'b0, 1'b0);
    watch(10);
    step("fwd1", 1'b0, 1'b1, 1'b0, 8'h01);
    step("fwd2", 1'b1, 1'b1, 1'b0, 8'h02);
    step("fwd3", 1'b1, 1'b0, 1'b0, 8'h03);
    step("fwd4", 1'b0, 1'b0, 1'b0, 8'h04);

    // Six reverse steps wrapping below zero.
    step("rev1", 1'b1, 1'b0, 1'b1, 8'h03);
    step("rev2", 1'b1, 1'b1, 1'b1, 8'h02);
    step("rev3", 1'b0, 1'b1, 1'b1, 8'h01);
    step("rev4", 1'b0, 1'b0, 1'b1, 8'h00);
    step("rev5", 1'b1, 1'b0, 1'b1, 8'hFF);
    step("rev6", 1'b1, 1'b1, 1'b1, 8'hFE);
    chk("rev_err_flag", 32'(bus.err_flag), 32'd0);

    // Glitch on A from AB=01: 3-cycle pulse is rejected, a held level is taken.
    step("to01", 1'b0, 1'b1, 1'b1, 8'hFD);
    bus.a_in = 1'b1;
    clr_counts();
    watch(3);
    bus.a_in = 1'b0;
    watch(10);
    chk("glitch_en_count",  32'(en_cnt), 32'd0);
    chk("glitch_err_count", 32'(err_cnt), 32'd0);
    chk("glitch_pos",       32'(bus.pos), 32'hFD);
    step("glitch_hold", 1'b1, 1'b1, 1'b0, 8'hFE);

    // Up through all-ones wrapping to zero, landing on AB=00.
    step("up_ff", 1'b1, 1'b0, 1'b0, 8'hFF);
    step("up_wrap", 1'b0, 1'b0, 1'b0, 8'h00);

    // Illegal 00 -> 11 double change.
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    clr_counts();
    watch(10);
    chk("ill_err_count", 32'(err_cnt), 32'd1);
    chk("ill_err_edge",  32'(first_er), 32'd7);
    chk("ill_en_count",  32'(en_cnt), 32'd0);
    chk("ill_err_flag",  32'(bus.err_flag), 32'd1);
    chk("ill_pos",       32'(bus.pos), 32'h00);
    chk("ill_dn",        32'(bus.dn), 32'd0);

    // Legal up step 11 -> 10 with clr landing on the same edge as en.
    bus.a_in = 1'b1;
    bus.b_in = 1'b0;
    clr_counts();
    watch(6);
    chk("clr_pre_en_count", 32'(en_cnt), 32'd0);
    bus.clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_en",       32'(bus.en), 32'd1);
    chk("clr_pos",      32'(bus.pos), 32'h00);
    chk("clr_err_flag", 32'(bus.err_flag), 32'd0);
    chk("clr_dn",       32'(bus.dn), 32'd0);
    chk("clr_err",      32'(bus.err), 32'd0);
    bus.clr = 1'b0;
    watch(3);

    // Zero minus one wraps to all-ones.
    step("down_wrap", 1'b1, 1'b1, 1'b1, 8'hFF);

    // Reset two cycles into a pending 11 -> 01 step.
    bus.a_in = 1'b0;
    clr_counts();
    watch(2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_pos", 32'(bus.pos), 32'd0);
    chk("mid_rst_dn",  32'(bus.dn), 32'd0);
    chk("mid_rst_en",  32'(bus.en), 32'd0);
    chk("mid_rst_err_flag", 32'(bus.err_flag), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_counts();
    watch(20);
    chk("mid_rst_en_count",  32'(en_cnt), 32'd0);
    chk("mid_rst_err_count", 32'(err_cnt), 32'd0);
    chk("mid_rst_pos_after", 32'(bus.pos), 32'd0);

    chk("en_err_overlap", 32'(both_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
